// File: rtl/mavg_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mavg_frame_sequencer
// Description : Frame controller around a parallel moving-average filter.
//               Gathers one frame of byte samples into a registered input
//               buffer that drives the filter, waits for the filter to
//               settle, snapshots the filter's parallel output, then streams
//               the snapshot out with valid/ready handshaking.
// Revision    : 1.0 - initial release
// ============================================================================
module mavg_frame_sequencer #(
    parameter int N_SAMP   = 256,
    parameter int DATA_W   = 8,
    parameter int TAPS     = 51,
    parameter int FILT_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              abort_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic [DATA_W-1:0] filt_in_o  [N_SAMP],
    input  logic [DATA_W-1:0] filt_out_i [N_SAMP],
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              out_warm_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    // Sample index counters span exactly one frame, so they never wrap
    // mid-frame; the settle counter covers FILT_LAT up to 15.
    localparam int              CNT_W    = $clog2(N_SAMP);
    localparam int              LAT_W    = 4;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMP - 1);
    localparam logic [CNT_W-1:0] WARM_IDX = CNT_W'(TAPS - 1);
    localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(FILT_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic               frame_done_q, frame_done_d;

    logic [DATA_W-1:0]  ibuf_q [N_SAMP];
    logic [DATA_W-1:0]  obuf_q [N_SAMP];

    // Strobes from the control logic into the buffer registers.
    logic               wr_en;
    logic               cap_en;

    // Control state, counters and the frame_done pulse register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            lat_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state, counter updates and handshake outputs; abort overrides all.
    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        frame_done_d = 1'b0;
        wr_en        = 1'b0;
        cap_en       = 1'b0;
        in_ready_o   = 1'b0;
        out_valid_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en_i) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    wr_en = 1'b1;
                    if (wr_cnt_q == LAST_IDX) begin
                        wr_cnt_d  = '0;
                        lat_cnt_d = '0;
                        state_d   = S_RUN;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end

            S_RUN: begin
                // The input buffer is frozen here; wait for the filter's
                // pipeline to reflect it before taking the snapshot.
                if (lat_cnt_q == LAT_END) begin
                    cap_en    = 1'b1;
                    lat_cnt_d = '0;
                    state_d   = S_DRAIN;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end

            S_DRAIN: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    if (rd_cnt_q == LAST_IDX) begin
                        rd_cnt_d     = '0;
                        frame_done_d = 1'b1;
                        state_d      = en_i ? S_LOAD : S_IDLE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A beat that coincides with abort is discarded along with the frame.
        if (abort_i) begin
            state_d      = S_IDLE;
            wr_cnt_d     = '0;
            rd_cnt_d     = '0;
            lat_cnt_d    = '0;
            frame_done_d = 1'b0;
            wr_en        = 1'b0;
            cap_en       = 1'b0;
        end
    end

    // Input buffer: written one sample at a time while loading only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_SAMP; i++) begin
                ibuf_q[i] <= '0;
            end
        end else if (wr_en) begin
            ibuf_q[wr_cnt_q] <= in_data_i;
        end
    end

    // Output buffer: whole filter result captured in a single cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_SAMP; i++) begin
                obuf_q[i] <= '0;
            end
        end else if (cap_en) begin
            for (int i = 0; i < N_SAMP; i++) begin
                obuf_q[i] <= filt_out_i[i];
            end
        end
    end

    // The filter always sees the registered input buffer.
    assign filt_in_o = ibuf_q;

    // Output sample decode; held at zero outside DRAIN.
    always_comb begin
        out_data_o = '0;
        out_last_o = 1'b0;
        out_warm_o = 1'b0;
        if (state_q == S_DRAIN) begin
            out_data_o = obuf_q[rd_cnt_q];
            out_last_o = (rd_cnt_q == LAST_IDX);
            out_warm_o = (rd_cnt_q >= WARM_IDX);
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mavg_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mavg_frame_sequencer
// Description : Self-checking bench for mavg_frame_sequencer with a registered
//               51-tap moving-average filter stub and a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mavg_frame_sequencer;

    localparam int N    = 256;
    localparam int W    = 8;
    localparam int TAPS = 51;
    localparam int LAT  = 1;
    localparam int BUDGET = 4000;

    logic         clk = 1'b0;
    logic         rst_n, en, abort;
    logic         in_valid, in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] filt_in  [N];
    logic [W-1:0] filt_out [N];
    logic         out_valid, out_ready, out_last, out_warm, busy, frame_done;
    logic [W-1:0] out_data;

    int errors = 0;
    int checks = 0;

    // Frame stimulus and collected output stream.
    logic [W-1:0] stim [N];
    logic [W-1:0] got_d [$];
    bit           got_l [$];
    bit           got_w [$];

    // Observations recorded by the frame runner.
    bit r_timeout;
    int r_done_early, r_extra, r_lat;
    bit r_done_end, r_done_next, r_ready_at_done, r_busy_at_done;

    always #5 clk = ~clk;

    mavg_frame_sequencer #(
        .N_SAMP(N), .DATA_W(W), .TAPS(TAPS), .FILT_LAT(LAT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .abort_i      (abort),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .filt_in_o    (filt_in),
        .filt_out_i   (filt_out),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_last_o   (out_last),
        .out_warm_o   (out_warm),
        .busy_o       (busy),
        .frame_done_o (frame_done)
    );

    // Registered filter stub: full-window average, zero before the window fills.
    always @(posedge clk) begin
        int s;
        s = 0;
        for (int i = 0; i < N; i++) begin
            s += int'(filt_in[i]);
            if (i >= TAPS) s -= int'(filt_in[i-TAPS]);
            filt_out[i] <= (i >= TAPS-1) ? W'(s / TAPS) : '0;
        end
    end

    // Reference: expected output sample i for the current stimulus frame.
    function automatic logic [W-1:0] model_out(input int i);
        int sum;
        if (i < TAPS-1) return '0;
        sum = 0;
        for (int j = i - (TAPS-1); j <= i; j++) sum += int'(stim[j]);
        return W'(sum / TAPS);
    endfunction

    // Drives one frame in and collects outputs until stop_out handshakes.
    // in_gap: drop in_valid every 3rd cycle and assert it with junk once loaded.
    // out_pat: 0 always ready, 1 one-on/two-off, 2 random.
    task automatic run_frame(input int in_gap, input int out_pat,
                             input bit en_after, input int stop_out);
        int wr, n_out, cyc, acc_cyc, fv_cyc;
        wr = 0; n_out = 0; cyc = 0; acc_cyc = -1; fv_cyc = -1;
        got_d.delete(); got_l.delete(); got_w.delete();
        r_timeout = 0; r_done_early = 0; r_extra = 0; r_lat = -1;
        r_done_end = 0; r_done_next = 1; r_ready_at_done = 0; r_busy_at_done = 1;
        while (n_out < stop_out) begin
            @(negedge clk);
            cyc++;
            if (cyc > BUDGET) begin
                r_timeout = 1;
                break;
            end
            if (frame_done) r_done_early++;
            if (out_valid && fv_cyc < 0) fv_cyc = cyc;
            if (wr < N) begin
                in_valid = (in_gap == 0) || (cyc % 3 != 0);
                in_data  = stim[wr];
            end else begin
                in_valid = (in_gap != 0);
                in_data  = W'($urandom);
            end
            if (in_valid && in_ready) begin
                if (wr < N) begin
                    wr++;
                    if (wr == 1) en = en_after;
                    if (wr == N) acc_cyc = cyc;
                end else begin
                    r_extra++;
                end
            end
            case (out_pat)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                got_w.push_back(out_warm);
                n_out++;
            end
        end
        if (fv_cyc >= 0 && acc_cyc >= 0) r_lat = fv_cyc - acc_cyc;
        if (n_out == N && !r_timeout) begin
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = 1'b0;
            r_done_end      = frame_done;
            r_ready_at_done = in_ready;
            r_busy_at_done  = busy;
            @(negedge clk);
            r_done_next = frame_done;
        end else begin
            in_valid  = 1'b0;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; abort = 1'b0; in_valid = 1'b1;
        in_data = 8'hAA; out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
            checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
            checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL rst_out_data got=%0d exp=0", out_data); end
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready got=%b exp=0", in_ready); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_ramp;
        for (int i = 0; i < N; i++) stim[i] = W'(i);
        en = 1'b1;
        run_frame(0, 0, 1'b0, N);
        checks++; if (r_timeout) begin errors++; $display("FAIL ramp_timeout got=1 exp=0"); end
        checks++; if (r_lat != LAT + 2) begin errors++; $display("FAIL ramp_latency got=%0d exp=%0d", r_lat, LAT + 2); end
        checks++; if (got_d.size() != N) begin errors++; $display("FAIL ramp_count got=%0d exp=%0d", got_d.size(), N); end
        for (int i = 0; i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== model_out(i)) begin errors++; $display("FAIL ramp_data[%0d] got=%0d exp=%0d", i, got_d[i], model_out(i)); end
            checks++; if (got_l[i] !== (i == N-1)) begin errors++; $display("FAIL ramp_last[%0d] got=%b exp=%b", i, got_l[i], i == N-1); end
            checks++; if (got_w[i] !== (i >= TAPS-1)) begin errors++; $display("FAIL ramp_warm[%0d] got=%b exp=%b", i, got_w[i], i >= TAPS-1); end
        end
        checks++; if (got_d.size() == N && got_d[50] !== 8'd25) begin errors++; $display("FAIL ramp_out50 got=%0d exp=25", got_d[50]); end
        checks++; if (got_d.size() == N && got_d[255] !== 8'd230) begin errors++; $display("FAIL ramp_out255 got=%0d exp=230", got_d[255]); end
        checks++; if (r_done_early != 0) begin errors++; $display("FAIL ramp_done_early got=%0d exp=0", r_done_early); end
        checks++; if (r_done_end !== 1'b1) begin errors++; $display("FAIL ramp_done_pulse got=%b exp=1", r_done_end); end
        checks++; if (r_done_next !== 1'b0) begin errors++; $display("FAIL ramp_done_width got=%b exp=0", r_done_next); end
        checks++; if (r_busy_at_done !== 1'b0) begin errors++; $display("FAIL ramp_idle_after got=%b exp=0", r_busy_at_done); end
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < N; i++) stim[i] = W'(i);
        en = 1'b1;
        run_frame(1, 1, 1'b0, N);
        checks++; if (r_timeout) begin errors++; $display("FAIL bp_timeout got=1 exp=0"); end
        checks++; if (got_d.size() != N) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", got_d.size(), N); end
        for (int i = 0; i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== model_out(i)) begin errors++; $display("FAIL bp_data[%0d] got=%0d exp=%0d", i, got_d[i], model_out(i)); end
            checks++; if (got_l[i] !== (i == N-1)) begin errors++; $display("FAIL bp_last[%0d] got=%b exp=%b", i, got_l[i], i == N-1); end
        end
        checks++; if (r_extra != 0) begin errors++; $display("FAIL bp_stray_accept got=%0d exp=0", r_extra); end
        checks++; if (r_done_end !== 1'b1) begin errors++; $display("FAIL bp_done_pulse got=%b exp=1", r_done_end); end
    endtask

    task automatic test_abort_mid_load;
        int waited;
        en = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!in_ready && waited < 20);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_load_entry got=%b exp=1", in_ready); end
        for (int i = 0; i < 100; i++) begin
            if (i != 0) @(negedge clk);
            in_valid = 1'b1;
            in_data  = W'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready got=%b exp=0", in_ready); end
        for (int i = 0; i < N; i++) stim[i] = 8'd200;
        run_frame(0, 0, 1'b0, N);
        checks++; if (r_timeout || got_d.size() != N) begin errors++; $display("FAIL abort_count got=%0d exp=%0d", got_d.size(), N); end
        for (int i = 0; i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== model_out(i)) begin errors++; $display("FAIL abort_data[%0d] got=%0d exp=%0d", i, got_d[i], model_out(i)); end
        end
        checks++; if (got_d.size() == N && got_d[200] !== 8'd200) begin errors++; $display("FAIL abort_warm200 got=%0d exp=200", got_d[200]); end
    endtask

    task automatic test_reset_mid_drain;
        for (int i = 0; i < N; i++) stim[i] = W'($urandom);
        en = 1'b1;
        run_frame(0, 2, 1'b1, 128);
        checks++; if (r_timeout) begin errors++; $display("FAIL rmd_timeout got=1 exp=0"); end
        @(posedge clk);
        #2;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmd_draining got=%b exp=1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmd_async_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmd_async_busy got=%b exp=0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) stim[i] = W'($urandom);
        run_frame(0, 2, 1'b0, N);
        checks++; if (r_timeout || got_d.size() != N) begin errors++; $display("FAIL rmd_count got=%0d exp=%0d", got_d.size(), N); end
        for (int i = 0; i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== model_out(i)) begin errors++; $display("FAIL rmd_data[%0d] got=%0d exp=%0d", i, got_d[i], model_out(i)); end
            checks++; if (got_w[i] !== (i >= TAPS-1)) begin errors++; $display("FAIL rmd_warm[%0d] got=%b exp=%b", i, got_w[i], i >= TAPS-1); end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < N; i++) stim[i] = W'(i);
        en = 1'b1;
        run_frame(0, 0, 1'b1, N);
        checks++; if (r_timeout || got_d.size() != N) begin errors++; $display("FAIL b2b_first_count got=%0d exp=%0d", got_d.size(), N); end
        checks++; if (got_d.size() == N && got_d[100] !== 8'd75) begin errors++; $display("FAIL b2b_first_out100 got=%0d exp=75", got_d[100]); end
        checks++; if (r_done_end !== 1'b1) begin errors++; $display("FAIL b2b_done_pulse got=%b exp=1", r_done_end); end
        checks++; if (r_ready_at_done !== 1'b1) begin errors++; $display("FAIL b2b_reload got=%b exp=1", r_ready_at_done); end
        for (int i = 0; i < N; i++) stim[i] = 8'd7;
        run_frame(0, 0, 1'b0, N);
        checks++; if (r_timeout || got_d.size() != N) begin errors++; $display("FAIL b2b_second_count got=%0d exp=%0d", got_d.size(), N); end
        for (int i = 0; i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== ((i >= TAPS-1) ? 8'd7 : 8'd0)) begin errors++; $display("FAIL b2b_second_data[%0d] got=%0d exp=%0d", i, got_d[i], (i >= TAPS-1) ? 7 : 0); end
        end
        checks++; if (r_done_end !== 1'b1) begin errors++; $display("FAIL b2b_second_done got=%b exp=1", r_done_end); end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_ramp();
        test_backpressure();
        test_abort_mid_load();
        test_reset_mid_drain();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
